poly_unpack_stream: RTL

Parametrised streaming coefficient unpacker. It is the successor of the fixed 12-bit poly_frombytes unpack state. It accepts a packed byte stream of `NUM_POLYS` polynomials over a valid/ready input. A bit-accumulator gearbox repacks the stream into `LANES` zero-extended coefficients per output beat, with full backpressure. It sits between the key/ciphertext byte buffers and the NTT/polyvec datapath, and it serves 12-bit (`poly_frombytes`), 10/4-bit (decompress) and 1-bit (msg) unpacking.

---
 rtl/poly_unpack_stream.sv | 111 +++++++++++
 1 files changed

// File: rtl/poly_unpack_stream.sv
// poly_unpack_stream: valid/ready bit-accumulator gearbox unpacking a packed byte stream into LANES zero-extended coefficients per beat (POLY_UNPACK_REDUCE_EN adds a single conditional subtract of KYBER_Q per lane and a sticky range_err)
module poly_unpack_stream #(
  parameter int KYBER_N = 256,
  parameter int NUM_POLYS = 2,
  parameter int COEFF_BITS = 12,
  parameter int COEFF_SZ = 16,
  parameter int LANES = 8,
  parameter int IN_BYTES = 4,
  parameter int KYBER_Q = 3329
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [8*IN_BYTES-1:0]     s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*COEFF_SZ-1:0] m_data,
  output logic [7:0]                m_poly_idx,
  output logic [7:0]                m_coeff_idx,
  output logic                      m_last,
  output logic                      busy,
  output logic                      done,
  output logic                      range_err
);
  localparam int EMIT_W = LANES*COEFF_BITS;
  localparam int IN_W = 8*IN_BYTES;
  localparam int ACC_W = EMIT_W + IN_W;
  localparam int FILL_W = $clog2(ACC_W+1);
  localparam int FRAME_BEATS = NUM_POLYS*KYBER_N*COEFF_BITS/IN_W;
  localparam int BEAT_W = $clog2(FRAME_BEATS+1);
  if ((KYBER_N % LANES) != 0 || ((KYBER_N*COEFF_BITS) % IN_W) != 0 || COEFF_BITS < 1 || COEFF_BITS > COEFF_SZ || KYBER_Q < 2) begin : g_bad_cfg
    $error("poly_unpack_stream: invalid parameter set");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [ACC_W-1:0] acc, acc_sh, acc_nx;
  logic [FILL_W-1:0] fill, fill_sh, fill_nx;
  logic [BEAT_W-1:0] beats;
  logic [7:0] coeff_cnt, poly_cnt;
  logic [LANES*COEFF_SZ-1:0] lanes;
  logic [LANES-1:0] err;
  logic accept, emit, wrap, final_hs;
  assign s_ready = state == RUN && fill <= FILL_W'(EMIT_W) && beats < BEAT_W'(FRAME_BEATS);
  assign accept = s_valid && s_ready;
  assign emit = state == RUN && fill >= FILL_W'(EMIT_W) && (!m_valid || m_ready);
  assign wrap = coeff_cnt == 8'(KYBER_N-LANES);
  assign final_hs = m_valid && m_ready && m_last && m_poly_idx == 8'(NUM_POLYS-1);
  assign busy = state == RUN;
  assign done = state == DONE;
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [COEFF_SZ-1:0] raw;
    assign raw = COEFF_SZ'(acc[j*COEFF_BITS +: COEFF_BITS]);
`ifdef POLY_UNPACK_REDUCE_EN
    assign err[j] = raw >= COEFF_SZ'(KYBER_Q);
    assign lanes[j*COEFF_SZ +: COEFF_SZ] = err[j] ? raw - COEFF_SZ'(KYBER_Q) : raw;
`else
    assign err[j] = 1'b0;
    assign lanes[j*COEFF_SZ +: COEFF_SZ] = raw;
`endif
  end
  // Emit consumes first so an appended beat lands right above the bits that remain.
  always_comb begin
    acc_sh = emit ? acc >> EMIT_W : acc;
    fill_sh = emit ? fill - FILL_W'(EMIT_W) : fill;
    acc_nx = accept ? acc_sh | (ACC_W'(s_data) << fill_sh) : acc_sh;
    fill_nx = accept ? fill_sh + FILL_W'(IN_W) : fill_sh;
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (final_hs ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      fill <= '0;
      beats <= '0;
      coeff_cnt <= '0;
      poly_cnt <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_poly_idx <= '0;
      m_coeff_idx <= '0;
      m_last <= 1'b0;
      range_err <= 1'b0;
    end else begin
      state <= state_nx;
      m_valid <= emit || (m_valid && !m_ready);
      if (state == IDLE && start) begin
        acc <= '0;
        fill <= '0;
        beats <= '0;
        coeff_cnt <= '0;
        poly_cnt <= '0;
        range_err <= 1'b0;
      end else begin
        acc <= acc_nx;
        fill <= fill_nx;
        if (accept) beats <= beats + BEAT_W'(1);
        if (emit) begin
          m_data <= lanes;
          m_coeff_idx <= coeff_cnt;
          m_poly_idx <= poly_cnt;
          m_last <= wrap;
          coeff_cnt <= wrap ? 8'd0 : coeff_cnt + 8'(LANES);
          poly_cnt <= wrap ? poly_cnt + 8'd1 : poly_cnt;
          range_err <= range_err || (|err);
        end
      end
    end
  end
endmodule
